// File: rtl/gpp_aes_pkg.sv
// gpp_aes_pkg: register offsets, FSM states and bit positions for the GPP AES controller
package gpp_aes_pkg;
  localparam logic [11:0] ADDR_CTRL   = 12'h000;
  localparam logic [11:0] ADDR_STATUS = 12'h004;
  localparam logic [11:0] ADDR_KEY    = 12'h010;
  localparam logic [11:0] ADDR_DIN    = 12'h020;
  localparam logic [11:0] ADDR_DOUT   = 12'h030;
  localparam int CTRL_START = 0;
  localparam int CTRL_DEC   = 1;
  localparam int CTRL_IRQ   = 2;
  localparam int CTRL_CLR   = 3;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, FIN} state_t;
endpackage

// File: rtl/gpp_aes_regs.sv
// gpp_aes_regs: APB decode, key/data register file and slave error generation
module gpp_aes_regs
  import gpp_aes_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     paddr,
  input  logic [31:0]     pwdata,
  input  logic            pwrite,
  input  logic            psel,
  input  logic            penable,
  output logic [31:0]     prdata,
  output logic            pready,
  output logic            pslverr,
  input  logic            busy,
  input  logic            done,
  input  logic            err,
  input  logic [7:0]      cnt,
  input  logic [3:0][31:0] dout,
  output logic [3:0][31:0] key,
  output logic [3:0][31:0] din,
  output logic            decrypt,
  output logic            irq_en,
  output logic            start_req,
  output logic            clr_req
);
  logic [11:0] a;
  logic acc, is_ctrl, is_stat, is_key, is_din, is_dout, bad, we;
  logic [31:0] st, rdata;
  always_comb begin
    a = paddr & ~12'h003;
    acc = psel & penable;
    is_ctrl = a == ADDR_CTRL;
    is_stat = a == ADDR_STATUS;
    is_key = a[11:4] == ADDR_KEY[11:4];
    is_din = a[11:4] == ADDR_DIN[11:4];
    is_dout = a[11:4] == ADDR_DOUT[11:4];
    // writes to live core inputs are refused while a run is in flight
    bad = acc & (~(is_ctrl | is_stat | is_key | is_din | is_dout) |
                 (pwrite & (is_stat | is_dout | (busy & (is_ctrl | is_key | is_din)))));
    we = acc & pwrite & ~bad;
    st = '0;
    st[ST_BUSY] = busy;
    st[ST_DONE] = done;
    st[ST_ERR] = err;
    st[15:8] = cnt;
    rdata = is_ctrl ? {29'b0, irq_en, decrypt, 1'b0} : is_stat ? st :
            is_key ? key[a[3:2]] : is_din ? din[a[3:2]] : is_dout ? dout[a[3:2]] : '0;
    prdata = (acc & ~pwrite & ~bad) ? rdata : '0;
    pready = acc;
    pslverr = bad;
    start_req = we & is_ctrl & pwdata[CTRL_START];
    clr_req = we & is_ctrl & pwdata[CTRL_CLR];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      key <= '0;
      din <= '0;
      decrypt <= 1'b0;
      irq_en <= 1'b0;
    end else if (we) begin
      if (is_ctrl) begin
        decrypt <= pwdata[CTRL_DEC];
        irq_en <= pwdata[CTRL_IRQ];
      end
      if (is_key) key[a[3:2]] <= pwdata;
      if (is_din) din[a[3:2]] <= pwdata;
    end
  end
endmodule

// File: rtl/gpp_aes_ctrl.sv
// gpp_aes_ctrl: APB3-controlled sequencer for one AES encrypt/decrypt per START
module gpp_aes_ctrl
  import gpp_aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [11:0]  paddr,
  input  logic [31:0]  pwdata,
  input  logic         pwrite,
  input  logic         psel,
  input  logic         penable,
  output logic [31:0]  prdata,
  output logic         pready,
  output logic         pslverr,
  output logic         aes_start,
  output logic         aes_decrypt,
  output logic [127:0] aes_key,
  output logic [127:0] aes_din,
  input  logic         aes_valid,
  input  logic [127:0] aes_dout,
  output logic         irq
);
  state_t state;
  logic [TO_W-1:0] to_cnt;
  logic [7:0] cyc;
  logic [127:0] dout;
  logic done, err, irq_en, start_req, clr_req;
  gpp_aes_regs u_regs (
    .clk(clk), .rst(rst), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(state != IDLE), .done(done), .err(err), .cnt(cyc), .dout(dout),
    .key(aes_key), .din(aes_din), .decrypt(aes_decrypt), .irq_en(irq_en),
    .start_req(start_req), .clr_req(clr_req)
  );
  assign irq = done & irq_en;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      to_cnt <= '0;
      cyc <= '0;
      dout <= '0;
      done <= 1'b0;
      err <= 1'b0;
      aes_start <= 1'b0;
    end else begin
      aes_start <= 1'b0;
      if (clr_req) begin
        done <= 1'b0;
        err <= 1'b0;
      end
      if (state == LOAD || state == WAIT) cyc <= cyc == 8'hff ? cyc : cyc + 8'd1;
      case (state)
        IDLE: if (start_req) begin
          state <= LOAD;
          aes_start <= 1'b1;
          done <= 1'b0;
          err <= 1'b0;
          cyc <= '0;
        end
        LOAD: begin
          state <= WAIT;
          to_cnt <= '0;
        end
        WAIT: if (aes_valid) begin
          dout <= aes_dout;
          done <= 1'b1;
          state <= FIN;
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err <= 1'b1;
          state <= IDLE;
        end else to_cnt <= to_cnt + TO_W'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpp_aes_ctrl.sv
// tb_gpp_aes_ctrl: directed scenario bench for gpp_aes_ctrl with a simple latency-programmable core model
module tb_gpp_aes_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0, prdata;
  logic pwrite = 1'b0, psel = 1'b0, penable = 1'b0, pready, pslverr;
  logic aes_start, aes_decrypt, aes_valid = 1'b0, irq;
  logic [127:0] aes_key, aes_din, aes_dout, resp = '0;
  int lat = 10, cd = 0, n_cmp = 0, n_bad = 0;
  logic stray = 1'b0, last_rdy, wr_prd;
  localparam logic [127:0] KEYV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] DINV = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R3 = 128'hfedcba98765432100123456789abcdef;
  gpp_aes_ctrl dut (
    .clk(clk), .rst(rst), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel),
    .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .aes_start(aes_start), .aes_decrypt(aes_decrypt), .aes_key(aes_key), .aes_din(aes_din),
    .aes_valid(aes_valid), .aes_dout(aes_dout), .irq(irq)
  );
  always #5 clk = ~clk;
  assign aes_dout = resp;
  // core model: valid pulses lat cycles after the start cycle; lat=0 means never
  always @(negedge clk) begin
    aes_valid = 1'b0;
    if (cd > 0) begin
      cd = cd - 1;
      aes_valid = (cd == 0);
    end
    if (stray) begin
      aes_valid = 1'b1;
      stray = 1'b0;
    end
    if (aes_start) cd = lat;
  end
  task automatic apb_wr(input logic [11:0] a, input logic [31:0] dat, output logic e);
    psel = 1; pwrite = 1; paddr = a; pwdata = dat;
    @(negedge clk); penable = 1; #1 e = pslverr; last_rdy = pready; wr_prd = |prdata;
    @(negedge clk); psel = 0; penable = 0; pwrite = 0;
  endtask
  task automatic apb_rd(input logic [11:0] a, output logic [31:0] dat, output logic e);
    psel = 1; pwrite = 0; paddr = a;
    @(negedge clk); penable = 1; #1 e = pslverr; dat = prdata; last_rdy = pready;
    @(negedge clk); psel = 0; penable = 0;
  endtask
  task automatic rd128(input logic [11:0] base, output logic [127:0] v);
    logic [31:0] d;
    logic e;
    for (int i = 0; i < 4; i++) begin
      apb_rd(base + 12'(4 * i), d, e);
      v[32*i +: 32] = d;
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if ({aes_start, aes_decrypt, irq, pready, pslverr} !== 5'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 00000", {aes_start, aes_decrypt, irq, pready, pslverr}); end
    n_cmp++; if ({aes_key, aes_din, prdata} !== '0) begin n_bad++; $display("FAIL reset_data: key %h din %h prdata %h want 0", aes_key, aes_din, prdata); end
    rst = 0;
  endtask
  task automatic test_encrypt();
    logic e;
    logic [31:0] d;
    logic [127:0] v;
    lat = 10; resp = C1;
    for (int i = 0; i < 4; i++) apb_wr(12'h010 + 12'(4 * i), KEYV[32*i +: 32], e);
    for (int i = 0; i < 4; i++) apb_wr(12'h020 + 12'(4 * i), DINV[32*i +: 32], e);
    apb_wr(12'h000, 32'h1, e);
    n_cmp++; if ({e, last_rdy} !== 2'b01) begin n_bad++; $display("FAIL start_wr: err/rdy %b want 01", {e, last_rdy}); end
    n_cmp++; if ({aes_start, aes_decrypt} !== 2'b10) begin n_bad++; $display("FAIL load_start: got %b want 10", {aes_start, aes_decrypt}); end
    n_cmp++; if (aes_key !== KEYV || aes_din !== DINV) begin n_bad++; $display("FAIL core_in: key %h din %h", aes_key, aes_din); end
    @(negedge clk);
    n_cmp++; if (aes_start !== 1'b0) begin n_bad++; $display("FAIL start_pulse: got %b want 0", aes_start); end
    repeat (9) @(negedge clk);
    apb_rd(12'h004, d, e);
    n_cmp++; if (d !== 32'h0b03) begin n_bad++; $display("FAIL fin_status: got %h want 00000b03", d); end
    apb_rd(12'h004, d, e);
    n_cmp++; if (d !== 32'h0b02) begin n_bad++; $display("FAIL enc_status: got %h want 00000b02", d); end
    rd128(12'h030, v);
    n_cmp++; if (v !== C1) begin n_bad++; $display("FAIL enc_dout: got %h want %h", v, C1); end
  endtask
  task automatic test_irq();
    logic e;
    logic [31:0] d;
    apb_wr(12'h000, 32'h5, e);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_start: got %b want 0", irq); end
    apb_rd(12'h000, d, e);
    n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL ctrl_rd: got %h want 4", d); end
    for (int i = 3; i <= 12; i++) begin
      @(negedge clk);
      n_cmp++; if (irq !== (i >= 11)) begin n_bad++; $display("FAIL irq_cyc%0d: got %b want %b", i, irq, i >= 11); end
    end
    apb_wr(12'h000, 32'h8, e);
    n_cmp++; if ({irq, e} !== 2'b00) begin n_bad++; $display("FAIL irq_clr: irq/err %b want 00", {irq, e}); end
    apb_rd(12'h004, d, e);
    n_cmp++; if (d !== 32'h0b00) begin n_bad++; $display("FAIL clr_status: got %h want 00000b00", d); end
  endtask
  task automatic test_busy_write();
    logic e;
    logic [31:0] d;
    logic [127:0] v;
    resp = R2;
    apb_wr(12'h000, 32'h3, e);
    apb_wr(12'h010, 32'hdeadbeef, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL key_busy_err: got %b want 1", e); end
    n_cmp++; if (aes_key !== KEYV || aes_decrypt !== 1'b1) begin n_bad++; $display("FAIL key_hold: key %h dec %b", aes_key, aes_decrypt); end
    apb_wr(12'h000, 32'h8, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL clr_busy_err: got %b want 1", e); end
    apb_wr(12'h02c, 32'h0, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL din_busy_err: got %b want 1", e); end
    apb_rd(12'h010, d, e);
    n_cmp++; if ({e, d} !== {1'b0, 32'h0c0d0e0f}) begin n_bad++; $display("FAIL key_busy_rd: err %b data %h want 0 0c0d0e0f", e, d); end
    repeat (4) @(negedge clk);
    apb_rd(12'h004, d, e);
    n_cmp++; if (d !== 32'h0b02) begin n_bad++; $display("FAIL dec_status: got %h want 00000b02", d); end
    apb_rd(12'h000, d, e);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL dec_ctrl: got %h want 2", d); end
    rd128(12'h030, v);
    n_cmp++; if (v !== R2) begin n_bad++; $display("FAIL dec_dout: got %h want %h", v, R2); end
  endtask
  task automatic test_timeout();
    logic e;
    logic [31:0] d;
    logic [127:0] v;
    lat = 0;
    apb_wr(12'h000, 32'h1, e);
    repeat (63) @(negedge clk);
    apb_rd(12'h004, d, e);
    n_cmp++; if (d !== 32'h4001) begin n_bad++; $display("FAIL to_cyc64: got %h want 00004001", d); end
    apb_wr(12'h000, 32'h1, e);
    repeat (64) @(negedge clk);
    apb_rd(12'h004, d, e);
    n_cmp++; if (d !== 32'h4104) begin n_bad++; $display("FAIL to_cyc65: got %h want 00004104", d); end
    rd128(12'h030, v);
    n_cmp++; if (v !== R2) begin n_bad++; $display("FAIL to_dout: got %h want %h", v, R2); end
    resp = ~R2; stray = 1;
    repeat (3) @(negedge clk);
    rd128(12'h030, v);
    n_cmp++; if (v !== R2) begin n_bad++; $display("FAIL stray_dout: got %h want %h", v, R2); end
    apb_rd(12'h004, d, e);
    n_cmp++; if (d !== 32'h4104) begin n_bad++; $display("FAIL stray_status: got %h want 00004104", d); end
  endtask
  task automatic test_errors();
    logic e;
    logic [31:0] d;
    logic [127:0] v;
    apb_rd(12'h040, d, e);
    n_cmp++; if ({e, d} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL rd_040: err %b data %h want 1 0", e, d); end
    apb_rd(12'h008, d, e);
    n_cmp++; if ({e, d} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL rd_008: err %b data %h want 1 0", e, d); end
    apb_wr(12'h030, 32'h12345678, e);
    n_cmp++; if ({e, wr_prd} !== 2'b10) begin n_bad++; $display("FAIL wr_030: err/prdata %b want 10", {e, wr_prd}); end
    apb_wr(12'h004, 32'h0, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL wr_stat: got %b want 1", e); end
    lat = 1; resp = R3;
    apb_wr(12'h000, 32'h1, e);
    @(negedge clk);
    apb_rd(12'h004, d, e);
    n_cmp++; if (d !== 32'h0203) begin n_bad++; $display("FAIL b2b_latency: got %h want 00000203", d); end
    rd128(12'h030, v);
    n_cmp++; if (v !== R3) begin n_bad++; $display("FAIL b2b_dout: got %h want %h", v, R3); end
  endtask
  task automatic test_reset_mid();
    logic e;
    logic [31:0] d;
    logic [127:0] v;
    lat = 10; resp = C1;
    apb_wr(12'h000, 32'h5, e);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_cmp++; if ({aes_key, aes_din, aes_decrypt, aes_start, irq} !== '0) begin n_bad++; $display("FAIL rst_mid_out: key %h din %h dec %b start %b irq %b", aes_key, aes_din, aes_decrypt, aes_start, irq); end
    repeat (10) @(negedge clk);
    apb_rd(12'h004, d, e);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_mid_status: got %h want 0", d); end
    apb_rd(12'h000, d, e);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_mid_ctrl: got %h want 0", d); end
    rd128(12'h030, v);
    n_cmp++; if (v !== '0) begin n_bad++; $display("FAIL rst_mid_dout: got %h want 0", v); end
    rd128(12'h010, v);
    n_cmp++; if (v !== '0) begin n_bad++; $display("FAIL rst_mid_key: got %h want 0", v); end
    rd128(12'h020, v);
    n_cmp++; if (v !== '0 || irq !== 1'b0) begin n_bad++; $display("FAIL rst_mid_din: got %h irq %b want 0", v, irq); end
  endtask
  initial begin
    test_reset();
    test_encrypt();
    test_irq();
    test_busy_write();
    test_timeout();
    test_errors();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
